alu_pipe: RTL

//   Parametrised, pipelined integer ALU; next generation of the single-cycle add/sub unit.

---
 rtl/alu_pipe_pkg.sv | 23 ++
 rtl/alu_pipe_if.sv | 35 +++
 rtl/alu_pipe_core.sv | 64 ++++++
 rtl/alu_pipe.sv | 97 +++++++++
 4 files changed

// File: rtl/alu_pipe_pkg.sv
// alu_pkg: shared opcode enum, opcode width and flag struct for the pipelined ALU.
package alu_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_SLT  = 3'd5,
        ALU_SLTU = 3'd6,
        ALU_PASS = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic ovf;
    } alu_flags_t;

endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand-in / result-out handshake bundle plus the completed-op count.
// master = producer/consumer side, slave = the ALU.
interface alu_pipe_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) ();

    logic              io_in_valid;
    logic              io_in_ready;
    logic [WIDTH-1:0]  io_in_a;
    logic [WIDTH-1:0]  io_in_b;
    logic [OP_W-1:0]   io_in_op;
    logic              io_out_valid;
    logic              io_out_ready;
    logic [WIDTH-1:0]  io_out_res;
    logic              io_out_zero;
    logic              io_out_carry;
    logic              io_out_ovf;
    logic [CNT_W-1:0]  io_count;

    modport master (
        output io_in_valid, io_in_a, io_in_b, io_in_op, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_res, io_out_zero,
               io_out_carry, io_out_ovf, io_count
    );

    modport slave (
        input  io_in_valid, io_in_a, io_in_b, io_in_op, io_out_ready,
        output io_in_ready, io_out_valid, io_out_res, io_out_zero,
               io_out_carry, io_out_ovf, io_count
    );

endinterface

// File: rtl/alu_pipe_core.sv
// alu_core: purely combinational op / flag compute for one operand pair.
// Optional feature macro: ALU_SAT_EN (signed saturation of ADD/SUB on overflow).
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          op,
    output logic [WIDTH-1:0] res,
    output alu_flags_t       flags
);

    localparam int MSB = WIDTH - 1;

    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             arith_ovf;
    logic [WIDTH-1:0] sat_val;

    // Shared adder: SUB is a + ~b + 1 so carry-out reads as no-borrow.
    always_comb begin
        is_sub    = (op == ALU_SUB);
        b_eff     = is_sub ? ~b : b;
        sum       = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        arith_ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]);
        // Overflow direction follows the operand sign: positive operands clip high.
        sat_val   = a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end

    // Result mux and flags; carry/ovf only meaningful for ADD/SUB.
    always_comb begin
        res   = '0;
        flags = '0;
        case (op)
            ALU_ADD, ALU_SUB: begin
`ifdef ALU_SAT_EN
                res = arith_ovf ? sat_val : sum[WIDTH-1:0];
`else
                res = sum[WIDTH-1:0];
`endif
                flags.carry = sum[WIDTH];
                flags.ovf   = arith_ovf;
            end
            ALU_AND:  res = a & b;
            ALU_OR:   res = a | b;
            ALU_XOR:  res = a ^ b;
            ALU_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: res = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_PASS: res = a;
            default:  res = '0;
        endcase
        flags.zero = (res == '0);
    end

`ifndef ALU_SAT_EN
    // Saturation value only feeds the saturating build.
    logic unused_sat;
    assign unused_sat = ^sat_val;
`endif

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: 2-stage pipelined integer ALU with valid/ready on both sides and
// a completed-op counter. S1 holds operands, S2 holds result + flags.
// Optional feature macro: ALU_SAT_EN (handled inside alu_core).
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic       clock,
    input  logic       reset,
    alu_pipe_if.slave  bus
);

    localparam int STAGES = 2;

    logic [STAGES:1]  vld_pipe;
    logic             adv1, adv2;
    logic             in_beat, out_beat;

    logic [WIDTH-1:0] a1, b1;
    alu_op_e          op1;

    logic [WIDTH-1:0] c_res;
    alu_flags_t       c_flags;

    logic [WIDTH-1:0] res2;
    alu_flags_t       flags2;
    logic [CNT_W-1:0] cnt;

    // Ready ripples back from the consumer; never depends on io_in_valid.
    always_comb begin
        adv2     = !vld_pipe[2] || bus.io_out_ready;
        adv1     = !vld_pipe[1] || adv2;
        in_beat  = bus.io_in_valid && adv1;
        out_beat = vld_pipe[2] && bus.io_out_ready;
    end

    // S1: capture operands on an in-beat; valid clears when drained with nothing new.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_pipe[1] <= 1'b0;
            a1          <= '0;
            b1          <= '0;
            op1         <= ALU_ADD;
        end else if (adv1) begin
            vld_pipe[1] <= bus.io_in_valid;
            if (bus.io_in_valid) begin
                a1  <= bus.io_in_a;
                b1  <= bus.io_in_b;
                op1 <= alu_op_e'(bus.io_in_op);
            end
        end
    end

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a     (a1),
        .b     (b1),
        .op    (op1),
        .res   (c_res),
        .flags (c_flags)
    );

    // S2: result register; data only loads with a valid S1 so outputs hold when idle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_pipe[2] <= 1'b0;
            res2        <= '0;
            flags2      <= '0;
        end else if (adv2) begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) begin
                res2   <= c_res;
                flags2 <= c_flags;
            end
        end
    end

    // Completed-op counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)        cnt <= '0;
        else if (out_beat) cnt <= cnt + 1'b1;
    end

    // in_beat is folded into the S1 enable; kept for readability of the handshake.
    logic unused_beat;
    assign unused_beat = in_beat;

    assign bus.io_in_ready  = adv1;
    assign bus.io_out_valid = vld_pipe[2];
    assign bus.io_out_res   = res2;
    assign bus.io_out_zero  = flags2.zero;
    assign bus.io_out_carry = flags2.carry;
    assign bus.io_out_ovf   = flags2.ovf;
    assign bus.io_count     = cnt;

endmodule
